// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: square-root FSM encoding and default widths.
package arith_pkg;
  localparam int RAD_W_DEF = 8;
  localparam int ROOT_W    = RAD_W_DEF / 2;
  localparam int REM_W     = RAD_W_DEF / 2 + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration; purely combinational.
// Consumes two radicand bits and produces one root bit.
module sqrt_step #(
  parameter int ROOT_W = 4
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        bits,
  output logic [ROOT_W+1:0] rem_next,
  output logic [ROOT_W-1:0] root_next
);
  localparam int RW = ROOT_W + 2;

  logic [RW+1:0] rem_t;
  logic [RW+1:0] trial;
  logic          ge;

  // Widened by two bits so the compare sees the full shifted remainder.
  assign rem_t = {rem, bits};
  assign trial = {2'b00, root, 2'b01};
  assign ge    = (rem_t >= trial);

  assign rem_next  = ge ? RW'(rem_t - trial) : RW'(rem_t);
  assign root_next = ROOT_W'({root, ge});
endmodule

// File: rtl/square_root_seq.sv
// Sequential integer square root, one root bit per clock; done RAD_W/2+1 cycles after start.
// start is ignored while busy; holding start in the DONE cycle chains the next operation.
module square_root_seq
  import arith_pkg::*;
#(
  parameter int RAD_W = RAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RAD_W-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [RAD_W/2-1:0]   root,
  output logic [RAD_W/2:0]     remainder,
  output logic                 exact
);
  localparam int RT_W  = RAD_W / 2;
  localparam int RM_W  = RT_W + 1;
  localparam int CNT_W = (RT_W > 1) ? $clog2(RT_W) : 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [RAD_W-1:0]  rad_sr;
  logic [RT_W+1:0]   rem_q, rem_n;
  logic [RT_W-1:0]   root_q, root_n;
  logic              accept;
  logic              last;

  assign accept = start && (state != CALC);
  assign last   = (cnt == CNT_W'(RT_W - 1));

  sqrt_step #(.ROOT_W(RT_W)) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .bits      (rad_sr[RAD_W-1 -: 2]),
    .rem_next  (rem_n),
    .root_next (root_n)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last)  state_n = DONE;
      DONE:    state_n = start ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rad_sr    <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      root      <= '0;
      remainder <= '0;
      exact     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rad_sr <= radicand;
        rem_q  <= '0;
        root_q <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        rad_sr <= rad_sr << 2;
        rem_q  <= rem_n;
        root_q <= root_n;
        cnt    <= cnt + 1'b1;
        // Final remainder is at most 2*root, so it always fits RM_W bits.
        if (last) begin
          root      <= root_n;
          remainder <= RM_W'(rem_n);
          exact     <= (rem_n == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_square_root_seq.sv
// Self-checking bench for square_root_seq: vector table, random and full sweep, handshake corner cases.
module tb_square_root_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] radicand;
  logic       busy;
  logic       done;
  logic [3:0] root;
  logic [4:0] remainder;
  logic       exact;

  int passed = 0;
  int total  = 0;

  square_root_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .radicand  (radicand),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder),
    .exact     (exact)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rad;
    int exp_root;
    int exp_rem;
    int exp_exact;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Pulses start for one cycle, then waits for done; returns the latched results and latency.
  task automatic run_op(input logic [7:0] r, output int ro, output int re, output int ex,
                        output int lat);
    int n;
    @(negedge clk);
    start = 1'b1;
    radicand = r;
    @(negedge clk);
    start = 1'b0;
    radicand = 8'($urandom);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    ro  = int'(root);
    re  = int'(remainder);
    ex  = int'(exact);
    lat = n;
  endtask

  initial begin
    vec_t vecs[$];
    int ro, re, ex, lat, n, pulses, m;
    logic [7:0] v;

    vecs.push_back('{144, 12, 0, 1});
    vecs.push_back('{200, 14, 4, 0});
    vecs.push_back('{255, 15, 30, 0});
    vecs.push_back('{0, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 1});
    vecs.push_back('{2, 1, 1, 0});
    vecs.push_back('{224, 14, 28, 0});
    vecs.push_back('{225, 15, 0, 1});

    rst = 1'b1;
    start = 1'b0;
    radicand = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_root", int'(root), 0);
    check("reset_rem", int'(remainder), 0);
    check("reset_exact", int'(exact), 0);
    rst = 1'b0;

    // Latency and busy profile on the first request.
    @(negedge clk);
    start = 1'b1;
    radicand = 8'd144;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("lat_busy", int'(busy), 1);
      check("lat_nodone", int'(done), 0);
      @(negedge clk);
    end
    check("lat_done", int'(done), 1);
    check("lat_busy_low", int'(busy), 0);
    check("lat_root", int'(root), 12);

    foreach (vecs[i]) begin
      run_op(8'(vecs[i].rad), ro, re, ex, lat);
      check("vec_latency", lat, 5);
      check("vec_root", ro, vecs[i].exp_root);
      check("vec_rem", re, vecs[i].exp_rem);
      check("vec_exact", ex, vecs[i].exp_exact);
    end

    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      run_op(v, ro, re, ex, lat);
      check("rand_root", ro, isqrt(int'(v)));
      check("rand_rem", re, int'(v) - isqrt(int'(v)) * isqrt(int'(v)));
    end

    for (int i = 0; i < 256; i++) begin
      run_op(8'(i), ro, re, ex, lat);
      check("sweep_bound", (ro * ro <= i && i < (ro + 1) * (ro + 1)) ? 1 : 0, 1);
      check("sweep_rem", re, i - isqrt(i) * isqrt(i));
      check("sweep_exact", ex, (i == isqrt(i) * isqrt(i)) ? 1 : 0);
    end

    // start with 50 while busy on 81 must be ignored.
    @(negedge clk);
    start = 1'b1;
    radicand = 8'd81;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    radicand = 8'd50;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_start_latency", n, 5);
    check("busy_start_root", int'(root), 9);
    check("busy_start_rem", int'(remainder), 0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_start_no_extra_done", pulses, 0);

    // Back-to-back: start held in the DONE cycle.
    run_op(8'd81, ro, re, ex, lat);
    check("b2b_first_root", ro, 9);
    check("b2b_first_rem", re, 0);
    check("b2b_first_exact", ex, 1);
    start = 1'b1;
    radicand = 8'd80;
    @(negedge clk);
    start = 1'b0;
    m = 1;
    pulses = 0;
    while (!done && m < 20) begin
      if (int'(root) != 9 || int'(remainder) != 0) pulses++;
      @(negedge clk);
      m++;
    end
    check("b2b_hold", pulses, 0);
    check("b2b_spacing", m, 5);
    check("b2b_second_root", int'(root), 8);
    check("b2b_second_rem", int'(remainder), 16);
    check("b2b_second_exact", int'(exact), 0);

    // Reset on the second CALC cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    radicand = 8'd200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_root", int'(root), 0);
    check("abort_rem", int'(remainder), 0);
    check("abort_exact", int'(exact), 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(8'd225, ro, re, ex, lat);
    check("after_abort_latency", lat, 5);
    check("after_abort_root", ro, 15);
    check("after_abort_rem", re, 0);
    check("after_abort_exact", ex, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
